// File: rtl/rule_table_access_ctrl.sv
// Host-side initiator for the TCAM rule-table req/ack register interface.
// Optional write read-back verify is enabled by defining RULE_ACC_VERIFY_EN.
module rule_table_access_ctrl #(
    parameter int unsigned TUPLE_WIDTH        = 104,
    parameter int unsigned MON_LUT_DEPTH_BITS = 5,
    parameter int unsigned NUM_RULES          = 16,
    parameter int unsigned TIMEOUT_CYCLES     = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          host_cmd_valid,
    output logic                          host_cmd_ready,
    input  logic                          host_cmd_wr,
    input  logic [MON_LUT_DEPTH_BITS-1:0] host_cmd_addr,
    input  logic [TUPLE_WIDTH-1:0]        host_cmd_rule,
    input  logic [TUPLE_WIDTH-1:0]        host_cmd_mask,
    output logic                          host_rsp_valid,
    output logic [1:0]                    host_rsp_status,
    output logic [TUPLE_WIDTH-1:0]        host_rsp_rule,
    output logic [TUPLE_WIDTH-1:0]        host_rsp_mask,
    output logic [MON_LUT_DEPTH_BITS-1:0] rule_rd_addr,
    output logic                          rule_rd_req,
    input  logic [TUPLE_WIDTH-1:0]        rule_rd,
    input  logic [TUPLE_WIDTH-1:0]        rule_rd_mask,
    input  logic                          rule_rd_ack,
    output logic [MON_LUT_DEPTH_BITS-1:0] rule_wr_addr,
    output logic                          rule_wr_req,
    output logic [TUPLE_WIDTH-1:0]        rule_wr,
    output logic [TUPLE_WIDTH-1:0]        rule_wr_mask,
    input  logic                          rule_wr_ack
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_TIMEOUT  = 2'd1;
    localparam logic [1:0] ST_BAD_ADDR = 2'd2;
`ifdef RULE_ACC_VERIFY_EN
    localparam logic [1:0] ST_VFY_FAIL = 2'd3;
`endif

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT,
        RESP
`ifdef RULE_ACC_VERIFY_EN
        ,
        VFY_ISSUE,
        VFY_WAIT
`endif
    } state_t;

    state_t                          state, state_n;
    logic [TW-1:0]                   timer, timer_n, timer_inc;
    logic                            expire;
    logic [MON_LUT_DEPTH_BITS-1:0]   hold_addr;
    logic [TUPLE_WIDTH-1:0]          hold_rule, hold_mask;
    logic [1:0]                      status_q, status_n;
    logic [TUPLE_WIDTH-1:0]          rsp_rule_q, rsp_rule_n;
    logic [TUPLE_WIDTH-1:0]          rsp_mask_q, rsp_mask_n;

    // Expiry is judged on the incremented value so a request is held for
    // exactly TIMEOUT_CYCLES cycles; an ack in that last cycle still wins.
    assign timer_inc = timer + 1'b1;
    assign expire    = (timer_inc == TW'(TIMEOUT_CYCLES));

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        status_n   = status_q;
        rsp_rule_n = rsp_rule_q;
        rsp_mask_n = rsp_mask_q;
        case (state)
            IDLE: begin
                if (host_cmd_valid) begin
                    timer_n    = '0;
                    status_n   = ST_OK;
                    rsp_rule_n = '0;
                    rsp_mask_n = '0;
                    if (32'(host_cmd_addr) >= NUM_RULES) begin
                        status_n = ST_BAD_ADDR;
                        state_n  = RESP;
                    end else if (host_cmd_wr) begin
                        state_n = WR_WAIT;
                    end else begin
                        state_n = RD_ISSUE;
                    end
                end
            end
            WR_WAIT: begin
                if (rule_wr_ack) begin
`ifdef RULE_ACC_VERIFY_EN
                    timer_n = '0;
                    state_n = VFY_ISSUE;
`else
                    status_n = ST_OK;
                    state_n  = RESP;
`endif
                end else if (expire) begin
                    status_n = ST_TIMEOUT;
                    state_n  = RESP;
                end else begin
                    timer_n = timer_inc;
                end
            end
            RD_ISSUE: state_n = RD_WAIT;
            RD_WAIT: begin
                if (rule_rd_ack) begin
                    status_n   = ST_OK;
                    rsp_rule_n = rule_rd;
                    rsp_mask_n = rule_rd_mask;
                    state_n    = RESP;
                end else if (expire) begin
                    status_n = ST_TIMEOUT;
                    state_n  = RESP;
                end else begin
                    timer_n = timer_inc;
                end
            end
`ifdef RULE_ACC_VERIFY_EN
            VFY_ISSUE: state_n = VFY_WAIT;
            VFY_WAIT: begin
                if (rule_rd_ack) begin
                    status_n   = ({rule_rd_mask, rule_rd} == {hold_mask, hold_rule})
                                 ? ST_OK : ST_VFY_FAIL;
                    rsp_rule_n = rule_rd;
                    rsp_mask_n = rule_rd_mask;
                    state_n    = RESP;
                end else if (expire) begin
                    status_n = ST_TIMEOUT;
                    state_n  = RESP;
                end else begin
                    timer_n = timer_inc;
                end
            end
`endif
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            hold_addr  <= '0;
            hold_rule  <= '0;
            hold_mask  <= '0;
            status_q   <= ST_OK;
            rsp_rule_q <= '0;
            rsp_mask_q <= '0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            status_q   <= status_n;
            rsp_rule_q <= rsp_rule_n;
            rsp_mask_q <= rsp_mask_n;
            if (state == IDLE && host_cmd_valid) begin
                hold_addr <= host_cmd_addr;
                hold_rule <= host_cmd_rule;
                hold_mask <= host_cmd_mask;
            end
        end
    end

    // Requests decode straight from state so reset drops them immediately.
    assign host_cmd_ready  = (state == IDLE);
    assign rule_wr_req     = (state == WR_WAIT);
`ifdef RULE_ACC_VERIFY_EN
    assign rule_rd_req     = (state == RD_ISSUE) || (state == VFY_ISSUE);
`else
    assign rule_rd_req     = (state == RD_ISSUE);
`endif
    assign host_rsp_valid  = (state == RESP);
    assign host_rsp_status = (state == RESP) ? status_q   : 2'd0;
    assign host_rsp_rule   = (state == RESP) ? rsp_rule_q : '0;
    assign host_rsp_mask   = (state == RESP) ? rsp_mask_q : '0;
    assign rule_rd_addr    = hold_addr;
    assign rule_wr_addr    = hold_addr;
    assign rule_wr         = hold_rule;
    assign rule_wr_mask    = hold_mask;

endmodule

// File: doc/rule_table_access_ctrl.md
Name: rule_table_access_ctrl

Overview:
Host-side initiator for the monitor TCAM rule-table register interface (rule_rd_*/rule_wr_* of the packet-filter lookup block). Accepts one rule read or write command at a time from the register/host side and drives the table's level-request/ack handshake. Returns rule data and a status code. Guards against stalls (TCAM busy) with a timeout, and rejects out-of-range addresses before touching the table.

Parameters:
TUPLE_WIDTH, 104, width of rule and rule mask
MON_LUT_DEPTH_BITS, 5, width of rule address
NUM_RULES, 16, number of valid table entries; addr >= NUM_RULES is rejected
TIMEOUT_CYCLES, 64, maximum cycles to wait for any ack (counter width = clog2(TIMEOUT_CYCLES+1))

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
host_cmd_valid  in  1  command present
host_cmd_ready  out  1  high only in IDLE
host_cmd_wr  in  1  1 = write rule, 0 = read rule
host_cmd_addr  in  MON_LUT_DEPTH_BITS  rule index
host_cmd_rule  in  TUPLE_WIDTH  rule value (write)
host_cmd_mask  in  TUPLE_WIDTH  rule mask (write)
host_rsp_valid  out  1  one-cycle pulse, command complete
host_rsp_status  out  2  0 OK, 1 TIMEOUT, 2 BAD_ADDR, 3 VERIFY_FAIL
host_rsp_rule  out  TUPLE_WIDTH  read data (reads and verify); 0 otherwise
host_rsp_mask  out  TUPLE_WIDTH  read mask; 0 otherwise
rule_rd_addr  out  MON_LUT_DEPTH_BITS  table read address
rule_rd_req  out  1  table read request
rule_rd  in  TUPLE_WIDTH  table read rule
rule_rd_mask  in  TUPLE_WIDTH  table read mask
rule_rd_ack  in  1  read ack pulse
rule_wr_addr  out  MON_LUT_DEPTH_BITS  table write address
rule_wr_req  out  1  table write request
rule_wr  out  TUPLE_WIDTH  write rule
rule_wr_mask  out  TUPLE_WIDTH  write mask
rule_wr_ack  in  1  write ack pulse

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0 except host_cmd_ready=1; timer 0. Reset mid-command abandons it: no response, requests drop immediately.
- Accept: host_cmd_valid && host_cmd_ready at an edge. Addr, rule, mask and wr are captured into holding regs; rule_*_addr/rule_wr/rule_wr_mask are driven from these regs.
- States: IDLE, WR_WAIT, RD_ISSUE, RD_WAIT, RESP (plus VFY_ISSUE, VFY_WAIT with the optional feature).
- IDLE: on accept, addr >= NUM_RULES -> RESP with BAD_ADDR, no table access. Write -> WR_WAIT with rule_wr_req=1 from the next cycle. Read -> RD_ISSUE.
- WR_WAIT: rule_wr_req held high, because the table acks only when the CAM is not busy. The cycle rule_wr_ack is sampled high, the next value of rule_wr_req is 0 and the state goes to RESP with OK. Req is never high for more than one cycle after ack, so no double write.
- RD_ISSUE: rule_rd_req=1 for exactly one cycle, because the table re-acks every cycle the req is held. Then RD_WAIT.
- RD_WAIT: on rule_rd_ack, capture rule_rd/rule_rd_mask and go to RESP with OK.
- Timer: cleared on entry to WR_WAIT, RD_ISSUE and VFY_ISSUE; increments each cycle in a wait state. When it reaches TIMEOUT_CYCLES with no ack: drop req, RESP with TIMEOUT and zero data.
- Ack arriving in the same cycle the timer expires counts as success.
- A stray ack in IDLE/RESP is ignored.
- RESP: host_rsp_valid=1 for one cycle with status/data, then IDLE. host_cmd_ready is 0 in RESP.
- Minimum latency, accept to rsp_valid: write = ack latency + 2; read = 1 + table read latency + 1.
- rule_rd_req and rule_wr_req are never high simultaneously.

Optional Feature:
RULE_ACC_VERIFY_EN.
- Defined: after a write ack, go to VFY_ISSUE/VFY_WAIT and read back the same address (same one-cycle req, same timeout).
- Verify passes if {rule_rd_mask, rule_rd} == {held mask, held rule}: status OK. Otherwise status VERIFY_FAIL.
- Readback data is returned on host_rsp_rule/mask either way. A timeout during verify returns TIMEOUT.
- Not defined: write responds OK directly after ack with zero data, and the VFY states do not exist.

Test Plan:
- Write addr 3, rule=104'hA5..., mask=104'hFF, table model acks 5 cycles after req: rule_wr_req high exactly until the ack cycle, one write. rsp OK 2 cycles after ack. With VERIFY_EN, readback matches and status is OK.
- Read addr 7, table model acks 2 cycles after a one-cycle req with rule=104'h1234: rule_rd_req is a single-cycle pulse. rsp_rule=104'h1234, status OK.
- Write with the table never acking: rule_wr_req drops after 64 cycles. rsp status=1 (TIMEOUT), data 0. host_cmd_ready returns next cycle.
- Command addr 16 (NUM_RULES=16): no rule_*_req asserted. rsp status=2 (BAD_ADDR) 2 cycles after accept.
- VERIFY_EN, model corrupts bit 0 on readback: status=3 (VERIFY_FAIL), corrupted value on rsp_rule.
- Assert reset during WR_WAIT: req drops asynchronously, no rsp_valid. A read issued after reset completes normally; a back-to-back command offered during RESP is not accepted until IDLE.
